// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared opcodes, constants and helpers for the
// multiply/divide unit (multdiv_unit and md_compute).
package multdiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Quotient on divide-by-zero: all ones.
    // Sliced to WIDTH, so WIDTH must be 64 or less.
    localparam logic [63:0] DIV0_LO = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Width of the countdown field.
    // cnt holds N-1, so clog2(max N) bits suffice.
    // Floor of 1 keeps the field legal when both latencies are 1.
    function automatic int cnt_width(input int m, input int d);
        int n;
        n = (m > d) ? m : d;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multdiv_unit_md_compute.sv
// md_compute: combinational multiply/divide datapath.
// Ports: op (3b opcode), a/b (WIDTH operands) -> res_hi/res_lo.
// mult/multu give the 2*WIDTH product as {res_hi,res_lo};
// div/divu give res_lo = quotient, res_hi = remainder;
// all other opcodes produce zero.
module md_compute
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic is_smul;
    logic is_umul;
    logic is_sdiv;
    logic is_udiv;
    logic div0;
    logic ovf;

    assign is_smul = (op == OP_MULT);
    assign is_umul = (op == OP_MULTU);
    assign is_sdiv = (op == OP_DIV);
    assign is_udiv = (op == OP_DIVU);

    assign div0 = (b == '0);
    assign ovf  = is_sdiv && (a == SMIN) && (b == '1);

    // Products of the extended operands, taken mod 2^(2W).
    // Sign extension makes the low 2W bits the signed product.
    logic [2*WIDTH-1:0] a_sx;
    logic [2*WIDTH-1:0] b_sx;
    logic [2*WIDTH-1:0] a_zx;
    logic [2*WIDTH-1:0] b_zx;
    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;

    assign a_sx  = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx  = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx  = {{WIDTH{1'b0}}, a};
    assign b_zx  = {{WIDTH{1'b0}}, b};
    assign sprod = a_sx * b_sx;
    assign uprod = a_zx * b_zx;

    // The dividers never see a zero divisor or the
    // SMIN / -1 pair; those results are patched below.
    logic [WIDTH-1:0] b_safe;
    assign b_safe = (div0 || ovf) ? ONE : b;

    logic signed [WIDTH-1:0] squo;
    logic signed [WIDTH-1:0] srem;
    logic [WIDTH-1:0]        uquo;
    logic [WIDTH-1:0]        urem;

    // Verilog signed / and % truncate toward zero, and the
    // remainder takes the sign of the dividend.
    assign squo = $signed(a) / $signed(b_safe);
    assign srem = $signed(a) % $signed(b_safe);
    assign uquo = a / b_safe;
    assign urem = a % b_safe;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        unique case (1'b1)
            is_smul: begin
                res_hi = sprod[2*WIDTH-1:WIDTH];
                res_lo = sprod[WIDTH-1:0];
            end
            is_umul: begin
                res_hi = uprod[2*WIDTH-1:WIDTH];
                res_lo = uprod[WIDTH-1:0];
            end
            is_sdiv, is_udiv: begin
                if (div0) begin
                    res_hi = a;
                    res_lo = DIV0_LO[WIDTH-1:0];
                end else if (ovf) begin
                    res_hi = '0;
                    res_lo = a;
                end else if (is_sdiv) begin
                    res_hi = srem;
                    res_lo = squo;
                end else begin
                    res_hi = urem;
                    res_lo = uquo;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle mult/div unit with HI/LO registers.
// Ports: clk, rst_n, start/op/a/b request, flush abort;
// busy (op in flight), hi/lo (architectural regs), done (commit pulse).
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    md_compute #(
        .WIDTH (WIDTH)
    ) u_compute (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;

    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_mthi = (op == OP_MTHI);
    assign is_mtlo = (op == OP_MTLO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Abort wins over commit and over a new start.
                state <= ST_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            unique case (1'b1)
                                is_mul, is_div: begin
                                    pend_hi <= res_hi;
                                    pend_lo <= res_lo;
                                    cnt     <= is_mul ? MULT_LOAD
                                                      : DIV_LOAD;
                                    state   <= ST_RUN;
                                    busy    <= 1'b1;
                                end
                                is_mthi: hi <= a;
                                is_mtlo: lo <= a;
                                default: ;
                            endcase
                        end
                    end
                    ST_RUN: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            hi    <= pend_hi;
                            lo    <= pend_lo;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Upstream stalls on busy, so a start here means a hazard bug.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(start && busy))
        else $warning("multdiv_unit: start ignored while busy");

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: table, random and sequence checks for
// multdiv_unit at default latency and at 1-cycle latency.
module tb_multdiv_unit;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         flush  = 1'b0;
    logic [2:0]   op     = 3'd0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic         start2 = 1'b0;
    logic         flush2 = 1'b0;
    logic [2:0]   op2    = 3'd0;
    logic         busy2;
    logic         done2;
    logic [W-1:0] hi2;
    logic [W-1:0] lo2;

    logic         sel = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;

    assign o_busy = sel ? busy2 : busy;
    assign o_done = sel ? done2 : done;
    assign o_hi   = sel ? hi2   : hi;
    assign o_lo   = sel ? lo2   : lo;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multdiv_unit #(
        .WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .flush(flush), .busy(busy),
        .hi(hi), .lo(lo), .done(done)
    );

    multdiv_unit #(
        .WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2),
        .a(a), .b(b), .flush(flush2), .busy(busy2),
        .hi(hi2), .lo(lo2), .done(done2)
    );

    // Reference: result pair {hi,lo} from the arithmetic rules.
    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        int          sx;
        int          sy;
        longint      sp;
        logic [31:0] q;
        logic [31:0] r;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin
                sp = longint'(sx) * longint'(sy);
                return 64'(sp);
            end
            3'd1: return 64'(x) * 64'(y);
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {32'h0, x};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        if (sel) begin start2 = 1'b1; op2 = o; end
        else     begin start  = 1'b1; op  = o; end
        a = x;
        b = y;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input int n, input logic [63:0] exp);
        logic [W-1:0] oh;
        logic [W-1:0] ol;
        int cyc;
        int dn;
        int stale;
        oh = o_hi;
        ol = o_lo;
        cyc = 0;
        dn = 0;
        stale = 0;
        issue(o, x, y);
        for (int k = 0; k < 40; k++) begin
            dn += int'(o_done);
            if (!o_busy) break;
            cyc++;
            if (o_hi !== oh || o_lo !== ol) stale++;
            @(negedge clk);
        end
        @(negedge clk);
        dn += int'(o_done);
        chk({nm, " busy cycles"}, 64'(cyc), 64'(n));
        chk({nm, " done pulses"}, 64'(dn), 64'd1);
        chk({nm, " hi/lo held"}, 64'(stale), 64'd0);
        chk({nm, " result"}, {o_hi, o_lo}, exp);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        int           rsel;
        int           hb;
        int           dn;
        logic [63:0]  mres;

        tbl[0] = '{3'd0, 32'hFFFF_FFFE, 32'h3,
                   32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFE, 32'h0000_0001, 5};
        tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'h2,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[3] = '{3'd3, 32'h7, 32'h0,
                   32'h7, 32'hFFFF_FFFF, 10};
        tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h0, 32'h8000_0000, 10};
        tbl[5] = '{3'd2, 32'hFFFF_FFFB, 32'h0,
                   32'hFFFF_FFFB, 32'hFFFF_FFFF, 10};
        tbl[6] = '{3'd3, 32'hFFFF_FFFF, 32'h10,
                   32'hF, 32'h0FFF_FFFF, 10};

        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a,
                   tbl[i].b, tbl[i].n, {tbl[i].hi, tbl[i].lo});

        for (int i = 0; i < 40; i++) begin
            ro   = 3'($urandom_range(0, 3));
            rx   = $urandom;
            ry   = $urandom;
            rsel = $urandom_range(0, 7);
            if (rsel == 0) ry = '0;
            if (rsel == 1) begin
                rx = 32'h8000_0000;
                ry = 32'hFFFF_FFFF;
            end
            if (rsel == 2) ry = $urandom_range(1, 16);
            if (rsel == 3) rx = $urandom_range(0, 100);
            run_op($sformatf("rnd%0d op%0d", i, ro), ro, rx, ry,
                   (ro < 3'd2) ? 5 : 10, model(ro, rx, ry));
        end

        // mthi then mtlo back to back
        hb = 0;
        dn = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'h1234;
        @(negedge clk);
        hb |= int'(busy);
        op = 3'd5; a = 32'h5678;
        @(negedge clk);
        hb |= int'(busy);
        dn |= int'(done);
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            hb |= int'(busy);
            dn |= int'(done);
        end
        chk("mthi hi", 64'(hi), 64'h1234);
        chk("mtlo lo", 64'(lo), 64'h5678);
        chk("mt busy", 64'(hb), 64'd0);
        chk("mt done", 64'(dn), 64'd0);

        // reserved opcode does nothing
        issue(3'd6, 32'hDEAD, 32'hBEEF);
        hb = int'(busy);
        @(negedge clk);
        hb |= int'(busy);
        chk("op6 busy", 64'(hb), 64'd0);
        chk("op6 hilo", {hi, lo}, {32'h1234, 32'h5678});

        // start during RUN is ignored
        mres = model(3'd0, 32'h7, 32'h6);
        issue(3'd0, 32'h7, 32'h6);
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        chk("mid-run mthi", 64'(hi), 64'h1234);
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("mid-run idle", 64'(busy), 64'd0);
        chk("mid-run result", {hi, lo}, mres);

        // flush on the third busy cycle
        issue(3'd4, 32'hAAAA, 32'h0);
        issue(3'd5, 32'hBBBB, 32'h0);
        issue(3'd0, 32'hFFFF_FFFE, 32'h3);
        dn = int'(done);
        @(negedge clk);
        dn |= int'(done);
        @(negedge clk);
        dn |= int'(done);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        repeat (8) begin
            dn |= int'(done);
            @(negedge clk);
        end
        chk("flush done", 64'(dn), 64'd0);
        chk("flush hilo", {hi, lo}, {32'hAAAA, 32'hBBBB});

        // flush and start together: start dropped
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'hFFFF; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush+start hi", 64'(hi), 64'hAAAA);

        // async reset between edges mid-RUN
        issue(3'd2, 32'd100, 32'd7);
        @(negedge clk);
        chk("pre-reset busy", 64'(busy), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async busy", 64'(busy), 64'd0);
        chk("async hi", 64'(hi), 64'd0);
        chk("async lo", 64'(lo), 64'd0);
        chk("async done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-cycle latency instance
        sel = 1'b1;
        run_op("lat1 mult", 3'd0, 32'hFFFF_FFFE, 32'h3, 1,
               model(3'd0, 32'hFFFF_FFFE, 32'h3));
        run_op("lat1 div", 3'd2, 32'hFFFF_FFF9, 32'h2, 1,
               model(3'd2, 32'hFFFF_FFF9, 32'h2));
        sel = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
